// File: rtl/flash_cmd_queue.sv
// flash_cmd_queue: in-order command FIFO between the host command decoder and
// the flash controller sequencer. Each entry is an opcode plus an address.
// Undefined opcodes are dropped with a one-cycle illegal_op pulse. A reset
// command jumps the queue: it discards every pending entry and becomes the
// only entry, pulsing flushed if anything was discarded.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake; in_op/in_addr carry the command
//   out_valid/out_ready    downstream handshake; out_op/out_addr show the head
//   count                  current occupancy
//   illegal_op             pulse: an undefined opcode was consumed and dropped
//   flushed                pulse: a reset command discarded >= 1 entries
module flash_cmd_queue #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 24,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_op,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  illegal_op,
  output logic                  flushed
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [2:0] OP_PROG    = 3'b001;
  localparam logic [2:0] OP_READ    = 3'b010;
  localparam logic [2:0] OP_ERASE   = 3'b100;
  localparam logic [2:0] OP_RESET   = 3'b011;
  localparam logic [2:0] OP_READ_ID = 3'b101;

  logic [2:0]            op_mem_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic                 flushed_q, flushed_d;

  logic             legal_c;
  logic             is_rst_cmd_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic [PTR_W-1:0] wr_idx_c;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Opcode decode.
  always_comb begin
    legal_c = 1'b0;
    case (in_op)
      OP_PROG, OP_READ, OP_ERASE, OP_RESET, OP_READ_ID: legal_c = 1'b1;
      default:                                          legal_c = 1'b0;
    endcase
  end

  assign is_rst_cmd_c = (in_op == OP_RESET);
  // Reset commands bypass the full check; everything else waits for space.
  assign in_ready     = (count_q < CNT_WIDTH'(DEPTH)) | is_rst_cmd_c;
  assign accept_c     = in_valid & in_ready;
  assign push_c       = accept_c & legal_c;
  assign pop_c        = out_valid & out_ready;
  // A reset command restarts the ring at slot 0.
  assign wr_idx_c     = is_rst_cmd_c ? '0 : wr_ptr_q;

  // Next-state for pointers, occupancy and status pulses.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = accept_c & ~legal_c;
    flushed_d = 1'b0;
    if (push_c && is_rst_cmd_c) begin
      wr_ptr_d  = PTR_W'(1);
      rd_ptr_d  = '0;
      count_d   = CNT_WIDTH'(1);
      // A head popped this same cycle was delivered, not discarded.
      flushed_d = (count_q - CNT_WIDTH'(pop_c)) != '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_c && !pop_c)      count_d = count_q + CNT_WIDTH'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      flushed_q <= flushed_d;
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      op_mem_q[wr_idx_c]   <= in_op;
      addr_mem_q[wr_idx_c] <= in_addr;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_op     = out_valid ? op_mem_q[rd_ptr_q]   : '0;
  assign out_addr   = out_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign illegal_op = illegal_q;
  assign flushed    = flushed_q;

endmodule

// File: tb/tb_flash_cmd_queue.sv
module tb_flash_cmd_queue;

  localparam int unsigned AW = 16;
  localparam int unsigned DEPTH = 24;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_op;
  logic [AW-1:0] out_addr;
  logic [CW-1:0] count;
  logic          illegal_op;
  logic          flushed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flash_cmd_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_addr(out_addr),
    .count(count), .illegal_op(illegal_op), .flushed(flushed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [2:0] op, input logic [AW-1:0] addr);
    in_valid = 1'b1; in_op = op; in_addr = addr;
    #1;
    chk("push_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0; in_op = 3'b000; in_addr = '0;
  endtask

  task automatic pop_chk(input string tag, input logic [2:0] op, input logic [AW-1:0] addr);
    out_ready = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_op"}, 32'(out_op), 32'(op));
    chk({tag, "_addr"}, 32'(out_addr), 32'(addr));
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_addr = '0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_flushed", 32'(flushed), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill with program_page 0..23
    for (int i = 0; i < 24; i++) push1(3'b001, AW'(i));
    chk("fill_count", 32'(count), 32'd24);
    // Full: non-reset command refused even while a pop happens
    in_valid = 1'b1; in_op = 3'b001; in_addr = 16'hAAAA; out_ready = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_addr", 32'(out_addr), 32'd0);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("after_pop_count", 32'(count), 32'd23);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 24; i++) pop_chk("drain", 3'b001, AW'(i));
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_op", 32'(out_op), 32'd0);
    chk("drain_addr", 32'(out_addr), 32'd0);
    // Empty: out_ready ignored
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);

    // Wrap-around
    for (int i = 0; i < 20; i++) push1(3'b010, AW'(16'h0100 + i));
    for (int i = 0; i < 20; i++) pop_chk("wrap_a", 3'b010, AW'(16'h0100 + i));
    for (int i = 0; i < 10; i++) push1(3'b100, AW'(16'h0200 + i));
    chk("wrap_count", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) pop_chk("wrap_b", 3'b100, AW'(16'h0200 + i));
    chk("wrap_end_count", 32'(count), 32'd0);

    // Illegal opcode with 3 queued
    for (int i = 0; i < 3; i++) push1(3'b001, AW'(16'h0010 + i));
    in_valid = 1'b1; in_op = 3'b110; in_addr = 16'h0055;
    #1;
    chk("ill_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0; in_op = 3'b000;
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_count", 32'(count), 32'd3);
    cyc();
    chk("ill_pulse_end", 32'(illegal_op), 32'd0);
    for (int i = 0; i < 3; i++) pop_chk("ill_pop", 3'b001, AW'(16'h0010 + i));
    chk("ill_end_count", 32'(count), 32'd0);

    // Reset jump while full, no pop
    for (int i = 0; i < 24; i++) push1(3'b001, AW'(16'h0300 + i));
    push1(3'b011, 16'hBEEF);
    chk("rj_count", 32'(count), 32'd1);
    chk("rj_op", 32'(out_op), 32'd3);
    chk("rj_flushed", 32'(flushed), 32'd1);
    cyc();
    chk("rj_flushed_end", 32'(flushed), 32'd0);
    pop_chk("rj_pop", 3'b011, 16'hBEEF);

    // Reset jump while full, head popped in the same cycle
    for (int i = 0; i < 24; i++) push1(3'b010, AW'(16'h0400 + i));
    in_valid = 1'b1; in_op = 3'b011; in_addr = 16'h1234; out_ready = 1'b1;
    #1;
    chk("rjp_ready", 32'(in_ready), 32'd1);
    chk("rjp_head_addr", 32'(out_addr), 32'h0400);
    chk("rjp_head_op", 32'(out_op), 32'd2);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rjp_count", 32'(count), 32'd1);
    chk("rjp_flushed", 32'(flushed), 32'd1);
    chk("rjp_op", 32'(out_op), 32'd3);
    chk("rjp_addr", 32'(out_addr), 32'h1234);
    // Only the popped head present: nothing discarded
    in_valid = 1'b1; in_op = 3'b011; in_addr = 16'h5678; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rjh_count", 32'(count), 32'd1);
    chk("rjh_flushed", 32'(flushed), 32'd0);
    pop_chk("rjh_pop", 3'b011, 16'h5678);
    // Reset into empty queue: no flush
    push1(3'b011, 16'h0042);
    chk("rje_count", 32'(count), 32'd1);
    chk("rje_flushed", 32'(flushed), 32'd0);
    pop_chk("rje_pop", 3'b011, 16'h0042);

    // Simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) push1(3'b010, AW'(16'h0500 + i));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = 3'b010; in_addr = AW'(16'h0505 + i); out_ready = 1'b1;
      #1;
      chk("sim_head", 32'(out_addr), 32'(16'h0500 + i));
      cyc();
      chk("sim_count", 32'(count), 32'd5);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pop_chk("sim_drain", 3'b010, AW'(16'h050A + i));

    // Mid-operation rst with a pending push
    for (int i = 0; i < 7; i++) push1(3'b101, AW'(16'h0700 + i));
    chk("mid_pre_count", 32'(count), 32'd7);
    in_valid = 1'b1; in_op = 3'b001; in_addr = 16'h0777; rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_flushed", 32'(flushed), 32'd0);
    chk("mid_addr", 32'(out_addr), 32'd0);
    cyc();
    chk("mid_count2", 32'(count), 32'd0);
    chk("mid_flushed2", 32'(flushed), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flash_cmd_queue.md
# flash_cmd_queue

Parametrised command queue between the host-side command decoder and the flash controller sequencer. It buffers up to DEPTH flash operations, each an opcode plus an address, and issues them in order over a valid/ready handshake. It rejects opcodes outside the defined operation set. A reset operation jumps the queue: it discards every pending command and becomes the only entry.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of the page/block address carried with each command
- DEPTH, 24, number of queue entries; any value ≥ 2, not required to be a power of two
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream command present
- in_ready  output  1  queue can accept the command on in_op/in_addr
- in_op  input  3  opcode: program_page=3'b001, read_page=3'b010, erase=3'b100, reset=3'b011, read_id=3'b101
- in_addr  input  ADDR_WIDTH  address for the command (stored but ignored for reset and read_id)
- out_valid  output  1  head entry available
- out_ready  input  1  sequencer takes the head entry
- out_op  output  3  head opcode
- out_addr  output  ADDR_WIDTH  head address
- count  output  CNT_WIDTH  current occupancy
- illegal_op  output  1  one-cycle pulse when an undefined opcode is dropped
- flushed  output  1  one-cycle pulse when a reset command discards one or more entries

## Operation
- Storage is a circular buffer with write and read pointers. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by natural binary overflow.
- The push condition is in_valid & in_ready & legal opcode.
- The pop condition is out_valid & out_ready.
- in_ready = (count < DEPTH) | (in_op == 3'b011). A reset command is always accepted, even when the queue is full.
- Illegal opcodes (3'b000, 3'b110, 3'b111) are handled as follows:
  - in_ready follows the count rule.
  - If in_valid & in_ready, the command is consumed but not stored, and illegal_op pulses in the next cycle.
  - count does not change.
- A normal push writes {op, addr} at the write pointer and advances it.
- A normal pop advances the read pointer.
- Simultaneous push and pop with count < DEPTH: both happen and count is unchanged.
- Reset-command push:
  - If a pop happens in the same cycle, the popped head is delivered normally.
  - All remaining entries are then discarded.
  - The reset command is written as the sole entry and count becomes 1.
  - flushed pulses in the next cycle only if at least one entry was discarded. A head popped in that cycle does not count as discarded.
  - If the queue was empty, or held only the head being popped, flushed stays 0.
- out_valid = (count != 0).
- out_op and out_addr show the head entry and are driven to 0 when count == 0.
- No pass-through path: a command pushed into an empty queue first appears on out_* in the following cycle.

## Timing
- On reset (rst high at a clock edge):
  - count=0, pointers=0, out_valid=0, out_op=0, out_addr=0, illegal_op=0, flushed=0.
  - in_ready goes high once count=0.
  - A rst asserted mid-operation discards all entries with no flushed pulse.
- Push-to-visible latency is 1 cycle. A push at edge N gives out_valid=1 after edge N.
- count, illegal_op and flushed are registered and update at the edge following the triggering handshake.
- in_ready is combinational on count and in_op only. It never depends on out_ready.
- Full (count == DEPTH) with a non-reset command:
  - in_ready=0, even if out_ready=1 in the same cycle.
  - The command is accepted one cycle after a pop.
- Empty (count == 0): out_ready is ignored and pointers hold.
- Back-to-back pushes every cycle are sustained until full. Back-to-back pops every cycle are sustained until empty.

## Test plan
- Reset then fill: push 24 program_page commands at addr 0..23 → count reaches 24 and in_ready=0. Then pop 24 → addresses come out 0..23 in order, and count returns to 0 with out_valid=0.
- Wrap-around: push 20, pop 20, push 10, pop 10 with DEPTH=24 → the pointers cross entry 23→0 and the outputs keep order with correct addresses.
- Illegal opcode: present 3'b110 with addr 0x55 while 3 entries are queued → illegal_op pulses once, count stays 3, and 0x55 never appears on out_addr.
- Reset jump while full: with 24 entries queued, push reset while out_ready=0 → next cycle count=1, out_op=3'b011 and flushed pulses. With out_ready=1 in that same cycle, the old head is delivered first, then count=1.
- Simultaneous push/pop at count=5: one read_page push and one pop per cycle for 10 cycles → count stays 5 and the order is preserved.
- Mid-operation rst: with 7 entries queued and a push pending, assert rst for 1 cycle → count=0, out_valid=0, flushed=0, and the pending push is not stored.
